// File: rtl/arbitro_pkg.sv
// Shared types and helpers for the round-robin complementoDos arbiter.
package arbitro_pkg;

    typedef enum logic [1:0] {ESPERA, CALCULO, ENTREGA} estado_t;

    // One-hot of idx, limited to m bits; callers size-cast to their width.
    function automatic logic [31:0] onehot(input int unsigned idx, input int unsigned m);
        onehot = (idx < m) ? (32'd1 << idx) : 32'd0;
    endfunction

endpackage

// File: rtl/complementoDos.sv
// Absolute value of a two's-complement operand; the most-negative value wraps to itself.
module complementoDos #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    output logic [N-1:0] y
);

    always_comb begin
        y = a[N-1] ? (~a + 1'b1) : a;
    end

endmodule

// File: rtl/rr_prioridad.sv
// Combinational round-robin pick: first set request searching upward from ptr+1 with wrap.
module rr_prioridad #(
    parameter  int unsigned M   = 4,
    localparam int unsigned IDW = $clog2(M)
) (
    input  logic [M-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] sel,
    output logic           hay_req
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        sel     = '0;
        found   = 1'b0;
        idx     = '0;
        hay_req = |req;
        // k = M lands back on ptr itself, so the last winner is checked last.
        for (int unsigned k = 1; k <= M; k++) begin
            idx = IDW'((32'(ptr) + k) % M);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_complemento.sv
// Round-robin arbiter sharing one complementoDos among M requesters, valid/ready result port.
module arbitro_complemento #(
    parameter  int unsigned N   = 4,
    parameter  int unsigned M   = 4,
    localparam int unsigned IDW = $clog2(M)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [M-1:0]   req,
    input  logic [M*N-1:0] a_in,
    output logic [M-1:0]   gnt,
    output logic [N-1:0]   y_out,
    output logic [IDW-1:0] y_id,
    output logic           y_valid,
    input  logic           y_ready,
    output logic           ocupado
);

    import arbitro_pkg::*;

    estado_t        estado_q;
    logic [IDW-1:0] ptr_q, reg_id_q, y_id_q, sel;
    logic [N-1:0]   reg_a_q, y_out_q, y_calc, a_sel;
    logic [M-1:0]   gnt_q;
    logic           y_valid_q, hay_req;

    rr_prioridad #(
        .M (M)
    ) u_rr (
        .req     (req),
        .ptr     (ptr_q),
        .sel     (sel),
        .hay_req (hay_req)
    );

    complementoDos #(
        .N (N)
    ) u_c2 (
        .a (reg_a_q),
        .y (y_calc)
    );

    always_comb begin
        a_sel = a_in[int'(sel)*N +: N];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q  <= ESPERA;
            ptr_q     <= IDW'(M - 1);
            reg_a_q   <= '0;
            reg_id_q  <= '0;
            gnt_q     <= '0;
            y_out_q   <= '0;
            y_id_q    <= '0;
            y_valid_q <= 1'b0;
        end else begin
            case (estado_q)
                ESPERA: begin
                    gnt_q <= '0;
                    if (hay_req) begin
                        reg_a_q  <= a_sel;
                        reg_id_q <= sel;
                        gnt_q    <= M'(onehot(32'(sel), M));
                        ptr_q    <= sel;
                        estado_q <= CALCULO;
                    end
                end
                CALCULO: begin
                    gnt_q     <= '0;
                    y_out_q   <= y_calc;
                    y_id_q    <= reg_id_q;
                    y_valid_q <= 1'b1;
                    estado_q  <= ENTREGA;
                end
                ENTREGA: begin
                    if (y_ready) begin
                        y_valid_q <= 1'b0;
                        estado_q  <= ESPERA;
                    end
                end
                default: begin
                    gnt_q     <= '0;
                    y_valid_q <= 1'b0;
                    estado_q  <= ESPERA;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign y_out   = y_out_q;
    assign y_id    = y_id_q;
    assign y_valid = y_valid_q;
    assign ocupado = (estado_q != ESPERA);

endmodule
